// File: rtl/ov7670_capture.sv
// ov7670_capture: captures one OV7670 RGB565 frame from the PCLK-synchronous
// camera bus and presents it as 16-bit FIFO writes.
//
// Optional feature: define CAPTURE_DECIMATE_EN to write only even pixels of
// even lines (2x2 decimation). Geometry checks always use full-resolution counts.
//
// Ports:
//   clk        camera PCLK; all logic runs on its rising edge
//   rst_n      asynchronous active-low reset
//   start      level; arms capture of the next full frame
//   vsync      camera VSYNC (high = vertical blanking)
//   href       camera HREF (high = valid bytes on din)
//   din        camera byte bus
//   full       downstream FIFO full
//   write      one-cycle FIFO write strobe
//   data_write RGB565 pixel, valid when write=1
//   frame_done one-cycle pulse at the end of a captured frame
//   busy       high while waiting for or capturing a frame
//   overflow   sticky: a pixel was dropped because full=1
//   geom_err   sticky: line or frame size mismatch
module ov7670_capture #(
   parameter int unsigned H_PIXELS = 640,
   parameter int unsigned V_LINES  = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  din,
   input  logic        full,
   output logic        write,
   output logic [15:0] data_write,
   output logic        frame_done,
   output logic        busy,
   output logic        overflow,
   output logic        geom_err
);

   localparam int unsigned PW = $clog2(H_PIXELS + 1);
   localparam int unsigned LW = $clog2(V_LINES + 1);
   localparam logic [PW-1:0] PIX_MAX  = {PW{1'b1}};
   localparam logic [LW-1:0] LINE_MAX = {LW{1'b1}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          vsync_q, href_q;
   logic          phase_q, phase_d;
   logic [7:0]    hi_q, hi_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [LW-1:0] line_q, line_d;
   logic          write_q, write_d;
   logic [15:0]   data_q, data_d;
   logic          fd_q, fd_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          gerr_q, gerr_d;

   logic vsync_fall, vsync_rise, href_fall;

   // Edge detection from a single registered copy of each camera strobe
   assign vsync_fall = vsync_q & ~vsync;
   assign vsync_rise = ~vsync_q & vsync;
   assign href_fall  = href_q & ~href;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start is a level, so dropping it while waiting disarms
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (start) state_d = WAIT_FRAME;
         WAIT_FRAME: begin
            if (!start)          state_d = IDLE;
            else if (vsync_fall) state_d = CAPTURE;
         end
         CAPTURE:    if (vsync_rise) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      logic keep;
      write_d = 1'b0;
      data_d  = data_q;
      fd_d    = 1'b0;
      busy_d  = (state_d != IDLE);
      ovf_d   = ovf_q;
      gerr_d  = gerr_q;
      phase_d = phase_q;
      hi_d    = hi_q;
      pix_d   = pix_q;
      line_d  = line_q;
      keep    = 1'b1;
`ifdef CAPTURE_DECIMATE_EN
      keep    = ~pix_q[0] & ~line_q[0];
`endif

      // Sticky flags are cleared when a new capture is armed
      if (state_q != WAIT_FRAME && state_d == WAIT_FRAME) begin
         ovf_d  = 1'b0;
         gerr_d = 1'b0;
      end

      if (state_q == WAIT_FRAME && state_d == CAPTURE) begin
         phase_d = 1'b0;
         pix_d   = '0;
         line_d  = '0;
      end

      if (state_q == CAPTURE) begin
         if (href) begin
            if (!phase_q) begin
               hi_d    = din;
               phase_d = 1'b1;
            end else begin
               // Pixel complete; it counts toward geometry even when dropped
               phase_d = 1'b0;
               pix_d   = (pix_q == PIX_MAX) ? pix_q : pix_q + PW'(1);
               if (keep) begin
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     write_d = 1'b1;
                     data_d  = {hi_q, din};
                  end
               end
            end
         end else begin
            phase_d = 1'b0;
            if (href_fall) begin
               // An odd trailing byte or a short/long line is a geometry error
               if (phase_q || pix_q != PW'(H_PIXELS)) gerr_d = 1'b1;
               pix_d  = '0;
               line_d = (line_q == LINE_MAX) ? line_q : line_q + LW'(1);
            end
         end

         if (vsync_rise) begin
            fd_d = 1'b1;
            if (line_d != LW'(V_LINES)) gerr_d = 1'b1;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         phase_q <= 1'b0;
         hi_q    <= '0;
         pix_q   <= '0;
         line_q  <= '0;
         write_q <= 1'b0;
         data_q  <= '0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         gerr_q  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         href_q  <= href;
         phase_q <= phase_d;
         hi_q    <= hi_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         write_q <= write_d;
         data_q  <= data_d;
         fd_q    <= fd_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         gerr_q  <= gerr_d;
      end
   end

   assign write      = write_q;
   assign data_write = data_q;
   assign frame_done = fd_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   assign geom_err   = gerr_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture with a 4x2 frame geometry.
module tb_ov7670_capture;

   logic        clk, rst_n, start, vsync, href, full;
   logic [7:0]  din;
   logic        write, frame_done, busy, overflow, geom_err;
   logic [15:0] data_write;

   ov7670_capture #(.H_PIXELS(4), .V_LINES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vsync(vsync), .href(href),
      .din(din), .full(full), .write(write), .data_write(data_write),
      .frame_done(frame_done), .busy(busy), .overflow(overflow), .geom_err(geom_err)
   );

`ifdef CAPTURE_DECIMATE_EN
   localparam int EXP_A = 2, EXP_B = 1, EXP_C = 2, EXP_R = 1;
`else
   localparam int EXP_A = 8, EXP_B = 7, EXP_C = 7, EXP_R = 2;
`endif

   logic [15:0] exp_q[$];
   int n_chk = 0, n_err = 0, n_wr = 0, n_fd = 0;
   int pix_g;
   logic [15:0] base;
   bit lat_chk = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic bit kept(input int p, input int l);
`ifdef CAPTURE_DECIMATE_EN
      return (p % 2 == 0) && (l % 2 == 0);
`else
      return 1'b1;
`endif
   endfunction

   // Monitor: every DUT write pops and compares one expected pixel
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (write === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_write: got %0h want none", data_write);
            end else begin
               e = exp_q.pop_front();
               check("pixel", 32'(data_write), 32'(e));
            end
         end
         if (frame_done === 1'b1) n_fd++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One camera line of nbytes; full is raised on the odd byte of pixel full_pix
   task automatic send_line(input int nbytes, input int l, input int full_pix, input bit cap);
      logic [15:0] v;
      for (int b = 0; b < nbytes; b++) begin
         v    = base + 16'(pix_g);
         href = 1'b1;
         din  = b[0] ? v[7:0] : v[15:8];
         full = b[0] && (pix_g == full_pix);
         if (b[0]) begin
            if (cap && kept(b / 2, l) && !full) exp_q.push_back(v);
            pix_g++;
         end
         tick();
         if (lat_chk && b == 1 && l == 0) begin
            check("latency_write", 32'(write), 32'd1);
            check("latency_data", 32'(data_write), 32'h1234);
         end
      end
      href = 1'b0;
      din  = 8'h00;
      full = 1'b0;
      ticks(2);
   endtask

   task automatic frame(input int bad_line, input int bad_bytes, input int full_pix,
                        input bit cap, input logic [15:0] b);
      base  = b;
      pix_g = 0;
      vsync = 1'b1;
      ticks(3);
      vsync = 1'b0;
      tick();
      start = 1'b0;   // dropping start mid-frame must not abort the capture
      ticks(2);
      for (int l = 0; l < 2; l++)
         send_line((l == bad_line) ? bad_bytes : 8, l, full_pix, cap);
      vsync = 1'b1;
      ticks(3);
   endtask

   initial begin
      int w0, f0;
      logic [15:0] v;
      rst_n = 0; start = 0; vsync = 0; href = 0; full = 0; din = 0;
      ticks(3);
      check("rst_write", 32'(write), 0);
      check("rst_data", 32'(data_write), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_geom_err", 32'(geom_err), 0);
      rst_n = 1;
      tick();

      // Normal frame, first pixel 0x1234
      start = 1; ticks(2);
      check("armed_busy", 32'(busy), 1);
      w0 = n_wr; f0 = n_fd;
      lat_chk = 1;
      frame(-1, 0, -1, 1, 16'h1234);
      lat_chk = 0;
      check("A_writes", 32'(n_wr - w0), 32'(EXP_A));
      check("A_frame_done", 32'(n_fd - f0), 1);
      check("A_geom_err", 32'(geom_err), 0);
      check("A_overflow", 32'(overflow), 0);
      check("A_busy_after", 32'(busy), 0);

      // FIFO full during the third pixel
      start = 1; ticks(2);
      w0 = n_wr; f0 = n_fd;
      frame(-1, 0, 2, 1, 16'h2000);
      check("B_writes", 32'(n_wr - w0), 32'(EXP_B));
      check("B_frame_done", 32'(n_fd - f0), 1);
      check("B_overflow", 32'(overflow), 1);
      check("B_geom_err", 32'(geom_err), 0);
      ticks(5);
      check("B_overflow_sticky", 32'(overflow), 1);

      // First line has 7 bytes
      start = 1; ticks(2);
      check("C_overflow_cleared", 32'(overflow), 0);
      w0 = n_wr; f0 = n_fd;
      frame(0, 7, -1, 1, 16'h3000);
      check("C_writes", 32'(n_wr - w0), 32'(EXP_C));
      check("C_geom_err", 32'(geom_err), 1);
      check("C_frame_done", 32'(n_fd - f0), 1);

      // Reset mid-line, released mid-frame
      start = 1; ticks(2);
      w0 = n_wr; f0 = n_fd;
      base = 16'h4000; pix_g = 0;
      vsync = 1; ticks(3); vsync = 0; ticks(3);
      for (int b = 0; b < 5; b++) begin
         v = base + 16'(pix_g);
         href = 1; din = b[0] ? v[7:0] : v[15:8];
         if (b[0]) begin
            if (kept(b / 2, 0)) exp_q.push_back(v);
            pix_g++;
         end
         tick();
      end
      rst_n = 0;
      #1;
      check("R_write_in_reset", 32'(write), 0);
      check("R_busy_in_reset", 32'(busy), 0);
      check("R_data_in_reset", 32'(data_write), 0);
      din = 8'hAA; ticks(2);
      rst_n = 1;
      for (int b = 0; b < 3; b++) begin din = 8'h55; tick(); end
      href = 0; din = 0; ticks(2);
      send_line(8, 1, -1, 0);
      vsync = 1; ticks(3);
      check("R_writes", 32'(n_wr - w0), 32'(EXP_R));
      check("R_frame_done", 32'(n_fd - f0), 0);
      check("R_busy_waiting", 32'(busy), 1);
      w0 = n_wr; f0 = n_fd;
      frame(-1, 0, -1, 1, 16'h5000);
      check("R2_writes", 32'(n_wr - w0), 32'(EXP_A));
      check("R2_frame_done", 32'(n_fd - f0), 1);
      check("R2_geom_err", 32'(geom_err), 0);

      // start low at vsync fall: nothing captured
      start = 0;
      w0 = n_wr; f0 = n_fd;
      frame(-1, 0, -1, 0, 16'h6000);
      check("E_writes", 32'(n_wr - w0), 0);
      check("E_busy", 32'(busy), 0);
      check("E_frame_done", 32'(n_fd - f0), 0);

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
